bcd_display_mux: RTL

Four-digit multiplexed seven-segment display driver for the user project area. It consumes the four BCD digit buses from the decimal counter (units, tens, hundreds, thousands) and drives a shared segment bus plus per-digit enables on user GPIOs. It sits between the counter outputs and `io_out`/`io_oeb` in the wrapper, clocked from `wb_clk_i`. It latches a coherent snapshot of the digits once per frame, so a display frame never shows a mid-count mix.

---
 rtl/bcd_display_mux_pkg.sv | 22 ++
 rtl/bcd_display_mux_to_seg7.sv | 26 ++
 rtl/bcd_display_mux.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bcd_display_mux_pkg.sv
// rtl/bcd_display_mux_pkg.sv - shared constants and types for the seven-segment display mux
package bcd_display_mux_pkg;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 7;

    typedef logic [1:0] digit_idx_t;

    // Active-high patterns, bit order g..a
    localparam logic [SEG_W-1:0] SEG_0    = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b1000000;

endpackage

// File: rtl/bcd_display_mux_to_seg7.sv
// rtl/bcd_display_mux_to_seg7.sv - combinational BCD digit to seven-segment decoder
module bcd_to_seg7
    import bcd_display_mux_pkg::*;
(
    input  logic [3:0]       digit_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - four-digit multiplexed seven-segment driver with per-frame snapshot
module bcd_display_mux
    import bcd_display_mux_pkg::*;
#(
    parameter int CLK_DIV          = 1000,
    parameter int BLANK_CYCLES     = 8,
    parameter bit SEG_ACTIVE_LOW   = 1'b0,
    parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              blank_lz,
    input  logic [3:0]        units,
    input  logic [3:0]        tens,
    input  logic [3:0]        hundreds,
    input  logic [3:0]        thousands,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [SEG_W-1:0]  seg,
    output logic              dp,
    output logic [DIGITS-1:0] digit_en,
    output logic              frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    digit_idx_t              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    primed_q, primed_d;
    logic [4*DIGITS-1:0]     snap_q, snap_d;
    logic [DIGITS-1:0]       snap_dp_q, snap_dp_d;
    logic                    tick_d;

    logic [SEG_W-1:0]        seg_q;
    logic                    dp_q;
    logic [DIGITS-1:0]       digit_en_q;
    logic                    frame_tick_q;

    logic                    slot_end;
    logic [3:0]              cur_digit;
    logic [SEG_W-1:0]        cur_seg;
    logic [DIGITS-1:0]       lz_blank;
    logic                    lit;

    assign slot_end = (cnt_q == CNT_LAST);

    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        primed_d  = primed_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        tick_d    = 1'b0;
        if (!enable) begin
            idx_d    = '0;
            cnt_d    = '0;
            primed_d = 1'b0;
        end else if (!primed_q) begin
            snap_d    = {thousands, hundreds, tens, units};
            snap_dp_d = dp_mask;
            primed_d  = 1'b1;
            tick_d    = 1'b1;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                snap_d    = {thousands, hundreds, tens, units};
                snap_dp_d = dp_mask;
                tick_d    = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign cur_digit = snap_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .digit_i (cur_digit),
        .seg_o   (cur_seg)
    );

    // Invalid BCD codes are nonzero, so they stop the leading-zero run
    always_comb begin
        lz_blank    = '0;
        lz_blank[3] = blank_lz && (snap_q[15:12] == 4'd0);
        lz_blank[2] = lz_blank[3] && (snap_q[11:8] == 4'd0);
        lz_blank[1] = lz_blank[2] && (snap_q[7:4] == 4'd0);
    end

    assign lit = enable && primed_q && (cnt_q >= CNT_BLANK) && !lz_blank[idx_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            primed_q     <= 1'b0;
            snap_q       <= '0;
            snap_dp_q    <= '0;
            seg_q        <= {SEG_W{SEG_ACTIVE_LOW}};
            dp_q         <= SEG_ACTIVE_LOW;
            digit_en_q   <= {DIGITS{DIGIT_ACTIVE_LOW}};
            frame_tick_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            primed_q     <= primed_d;
            snap_q       <= snap_d;
            snap_dp_q    <= snap_dp_d;
            seg_q        <= (lit ? cur_seg : '0) ^ {SEG_W{SEG_ACTIVE_LOW}};
            dp_q         <= (lit && snap_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
            digit_en_q   <= (lit ? (DIGITS'(1) << idx_q) : '0) ^ {DIGITS{DIGIT_ACTIVE_LOW}};
            frame_tick_q <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_en   = digit_en_q;
    assign frame_tick = frame_tick_q;

endmodule
